branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  Parametrised branch target buffer with a 2-bit bimodal history table. Sits beside fetch.
//  It predicts the taken/target for the PC in IF, so that taken branches/jumps no longer wait for EX.
//  It also resolves the prediction in EX and produces the mispredict flag and corrected next PC.
//  Mispredict drives the PC select and FlushD/FlushE. Perf counters are included.
// PARAMETERS
//  DATA_WIDTH  32  PC/target width
//  ENTRIES     16  table entries, power of 2 (>=2); INDEX_BITS = $clog2(ENTRIES)
//  CTR_INIT    1   counter reset value (2'b01, weakly not-taken)
//  PERF_WIDTH  32  width of perf counters
// PORTS
//  clk               in   1           rising-edge clock
//  reset             in   1           asynchronous, active-high
//  pc_f              in   DATA_WIDTH  fetch PC
//  pred_taken_f      out  1           predict taken for pc_f
//  pred_target_f     out  DATA_WIDTH  predicted target (0 when pred_taken_f=0)
//  upd_valid_e       in   1           EX holds a resolved branch/jump
//  upd_is_jump_e     in   1           unconditional (jal/jalr)
//  upd_pc_e          in   DATA_WIDTH  PC of the resolved instruction
//  upd_taken_e       in   1           actual direction
//  upd_target_e      in   DATA_WIDTH  actual target
//  upd_pred_taken_e  in   1           pred_taken_f piped to EX
//  upd_pred_target_e in   DATA_WIDTH  pred_target_f piped to EX
//  mispredict_e      out  1           redirect + flush required
//  redirect_pc_e     out  DATA_WIDTH  correct next PC
//  branch_cnt        out  PERF_WIDTH  resolved branches/jumps
//  mispred_cnt       out  PERF_WIDTH  mispredictions
// BEHAVIOUR
//  Clock/reset: single clock clk; reset asynchronous, active-high.
//  Reset: all valid=0, all ctr=CTR_INIT, tags/targets=0, perf counters=0.
//    Hence pred_taken_f=0 and pred_target_f=0 immediately, without waiting for a clock.
//  Address fields: idx = pc[INDEX_BITS+1:2]; tag = pc[DATA_WIDTH-1:INDEX_BITS+2]; pc[1:0] ignored.
//  Lookup (0-cycle, combinational from registered table):
//    hit = valid[idx] & (tag[idx]==tag(pc_f)).
//    pred_taken_f = hit & (ctr[idx][1] | jmp[idx]).
//    pred_target_f = pred_taken_f ? target[idx] : 0.
//  Resolve (combinational, qualified by upd_valid_e; outputs 0 when upd_valid_e=0):
//    mispredict_e = (upd_taken_e != upd_pred_taken_e) | (upd_taken_e & upd_target_e != upd_pred_target_e).
//    redirect_pc_e = upd_taken_e ? upd_target_e : upd_pc_e+4 (mod 2^DATA_WIDTH).
//  Update (rising edge with upd_valid_e):
//    hit at upd_pc_e:
//      taken: ctr = min(ctr+1, 3).
//      not taken: ctr = max(ctr-1, 0).
//      if taken, target <= upd_target_e; jmp <= upd_is_jump_e.
//    miss & taken: allocate or overwrite idx.
//      valid=1, tag, target, jmp=upd_is_jump_e.
//      ctr = jump ? 2'b11 : 2'b10.
//    miss & not taken: no table change.
//  Simultaneous lookup and update to the same idx: the lookup sees the pre-edge contents (read-old).
//    The new contents are visible the next cycle.
//  Perf counters: branch_cnt +1 per upd_valid_e cycle; mispred_cnt +1 per mispredict_e cycle.
//    Both saturate at all-ones (no wrap).
//  Reset asserted mid-operation: the state clears at once. An update on the same edge is discarded.
// STRUCTURE
//  Shared package bp_pkg:
//    counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
//    function ctr_next(ctr, taken).
//    entry struct {valid, tag, target, ctr, jmp}.
//  One sub-module: bp_entry_table.
//    ENTRIES-deep register array, async reset.
//    One combinational read port (fetch) and one read/write port (EX).
//  Resolve logic and perf counters live in the top.
// TESTING (ENTRIES=16, idx=pc[5:2])
//  1 Reset: assert reset, pc_f=0x00400010 -> pred_taken_f=0, pred_target_f=0, branch_cnt=0, mispred_cnt=0.
//  2 Allocate: upd pc 0x00400010, taken, target 0x00400000, pred 0.
//    -> mispredict_e=1, redirect_pc_e=0x00400000.
//    Next cycle pc_f=0x00400010 -> pred_taken_f=1, pred_target_f=0x00400000.
//  3 Counter saturation at pc 0x00400010 (ctr=WT):
//    not-taken x3 -> ctr 01, 00, 00; pred 0 after the first.
//    taken x2 -> 01 then 10; pred 1.
//    Not-taken with pred 0 -> mispredict_e=0, redirect_pc_e=0x00400014.
//  4 Alias/jump: taken jump at 0x00400050 (idx 4), target 0x00400100 -> evicts entry.
//    pc_f=0x00400010 -> pred 0.
//    pc_f=0x00400050 -> pred 1 (ctr=11).
//  5 Wrong target: predicted taken to 0x00400100, actual taken to 0x00400200.
//    -> mispredict_e=1, redirect 0x00400200; entry target updated.
//    Update and lookup of the same idx in one cycle -> lookup shows old target.
//  6 Perf + async reset: preload PERF_WIDTH=4 counters to 15, one more update -> stays 15.
//    Pulse reset between edges -> counters 0 and pred_taken_f=0 before the next edge.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter encoding
// and the saturating counter step function.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    function automatic bp_ctr_e ctr_next(input bp_ctr_e ctr, input logic taken);
        bp_ctr_e nxt;
        nxt = ctr;
        unique case (ctr)
            SNT:     nxt = taken ? WNT : SNT;
            WNT:     nxt = taken ? WT  : SNT;
            WT:      nxt = taken ? ST  : WNT;
            ST:      nxt = taken ? ST  : WT;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/bp_entry_table.sv
// BTB storage: register array with a fetch read port and an
// EX read/write port; reads return pre-edge contents.
module bp_entry_table
    import bp_pkg::*;
#(
    parameter int     ENTRIES    = 16,
    parameter int     INDEX_BITS = $clog2(ENTRIES),
    parameter type    entry_t    = logic [0:0],
    parameter entry_t RST_ENTRY  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output entry_t                rd_entry,
    input  logic [INDEX_BITS-1:0] ex_idx,
    output entry_t                ex_entry,
    input  logic                  ex_we,
    input  entry_t                ex_wdata
);

    entry_t mem [ENTRIES];

    assign rd_entry = mem[rd_idx];
    assign ex_entry = mem[ex_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                mem[i] <= RST_ENTRY;
            end
        end else if (ex_we) begin
            mem[ex_idx] <= ex_wdata;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// BTB + bimodal predictor: IF lookup, EX resolve/redirect,
// table update and saturating perf counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         ENTRIES    = 16,
    parameter logic [1:0] CTR_INIT   = 2'd1,
    parameter int         PERF_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] pc_f,
    output logic                  pred_taken_f,
    output logic [DATA_WIDTH-1:0] pred_target_f,
    input  logic                  upd_valid_e,
    input  logic                  upd_is_jump_e,
    input  logic [DATA_WIDTH-1:0] upd_pc_e,
    input  logic                  upd_taken_e,
    input  logic [DATA_WIDTH-1:0] upd_target_e,
    input  logic                  upd_pred_taken_e,
    input  logic [DATA_WIDTH-1:0] upd_pred_target_e,
    output logic                  mispredict_e,
    output logic [DATA_WIDTH-1:0] redirect_pc_e,
    output logic [PERF_WIDTH-1:0] branch_cnt,
    output logic [PERF_WIDTH-1:0] mispred_cnt
);

    localparam int INDEX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS   = DATA_WIDTH - INDEX_BITS - 2;

    typedef struct packed {
        logic                  valid;
        logic [TAG_BITS-1:0]   tag;
        logic [DATA_WIDTH-1:0] target;
        bp_ctr_e               ctr;
        logic                  jmp;
    } entry_t;

    localparam entry_t RST_ENTRY = '{
        valid:  1'b0,
        tag:    '0,
        target: '0,
        ctr:    bp_ctr_e'(CTR_INIT),
        jmp:    1'b0
    };

    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    logic [TAG_BITS-1:0]   tag_f;
    logic [TAG_BITS-1:0]   tag_e;
    entry_t                rd_entry;
    entry_t                ex_entry;
    entry_t                wr_entry;
    logic                  hit_f;
    logic                  hit_e;
    logic                  we;
    logic                  unused_lsb;

    assign idx_f = pc_f[INDEX_BITS+1:2];
    assign tag_f = pc_f[DATA_WIDTH-1:INDEX_BITS+2];
    assign idx_e = upd_pc_e[INDEX_BITS+1:2];
    assign tag_e = upd_pc_e[DATA_WIDTH-1:INDEX_BITS+2];

    assign unused_lsb = ^{pc_f[1:0], upd_pc_e[1:0]};

    bp_entry_table #(
        .ENTRIES    (ENTRIES),
        .INDEX_BITS (INDEX_BITS),
        .entry_t    (entry_t),
        .RST_ENTRY  (RST_ENTRY)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (idx_f),
        .rd_entry (rd_entry),
        .ex_idx   (idx_e),
        .ex_entry (ex_entry),
        .ex_we    (we),
        .ex_wdata (wr_entry)
    );

    assign hit_f         = rd_entry.valid & (rd_entry.tag == tag_f);
    assign pred_taken_f  = hit_f & (rd_entry.ctr[1] | rd_entry.jmp);
    assign pred_target_f = pred_taken_f ? rd_entry.target : '0;

    always_comb begin
        mispredict_e  = 1'b0;
        redirect_pc_e = '0;
        if (upd_valid_e) begin
            mispredict_e = (upd_taken_e != upd_pred_taken_e) |
                           (upd_taken_e & (upd_target_e != upd_pred_target_e));
            redirect_pc_e = upd_taken_e ? upd_target_e
                                        : upd_pc_e + DATA_WIDTH'(4);
        end
    end

    assign hit_e = ex_entry.valid & (ex_entry.tag == tag_e);
    assign we    = upd_valid_e & (hit_e | upd_taken_e);

    // Hits train the counter; taken misses (re)allocate the slot.
    always_comb begin
        wr_entry     = ex_entry;
        wr_entry.ctr = ctr_next(ex_entry.ctr, upd_taken_e);
        if (upd_taken_e) begin
            wr_entry.target = upd_target_e;
            wr_entry.jmp    = upd_is_jump_e;
        end
        if (!hit_e) begin
            wr_entry.valid  = 1'b1;
            wr_entry.tag    = tag_e;
            wr_entry.target = upd_target_e;
            wr_entry.jmp    = upd_is_jump_e;
            wr_entry.ctr    = upd_is_jump_e ? ST : WT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (upd_valid_e && branch_cnt != '1) begin
                branch_cnt <= branch_cnt + PERF_WIDTH'(1);
            end
            if (mispredict_e && mispred_cnt != '1) begin
                mispred_cnt <= mispred_cnt + PERF_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table applied
// through an expected-result queue, plus reset corner sequences.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        upd_valid_e;
    logic        upd_is_jump_e;
    logic [31:0] upd_pc_e;
    logic        upd_taken_e;
    logic [31:0] upd_target_e;
    logic        upd_pred_taken_e;
    logic [31:0] upd_pred_target_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic [3:0]  branch_cnt;
    logic [3:0]  mispred_cnt;

    branch_predictor #(
        .DATA_WIDTH (32),
        .ENTRIES    (16),
        .CTR_INIT   (2'd1),
        .PERF_WIDTH (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .pc_f              (pc_f),
        .pred_taken_f      (pred_taken_f),
        .pred_target_f     (pred_target_f),
        .upd_valid_e       (upd_valid_e),
        .upd_is_jump_e     (upd_is_jump_e),
        .upd_pc_e          (upd_pc_e),
        .upd_taken_e       (upd_taken_e),
        .upd_target_e      (upd_target_e),
        .upd_pred_taken_e  (upd_pred_taken_e),
        .upd_pred_target_e (upd_pred_target_e),
        .mispredict_e      (mispredict_e),
        .redirect_pc_e     (redirect_pc_e),
        .branch_cnt        (branch_cnt),
        .mispred_cnt       (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        uv;
        logic        uj;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_rd;
    } vec_t;

    localparam logic [31:0] PA = 32'h0040_0010;
    localparam logic [31:0] PB = 32'h0040_0050;
    localparam logic [31:0] T0 = 32'h0040_0000;
    localparam logic [31:0] T1 = 32'h0040_0100;
    localparam logic [31:0] T2 = 32'h0040_0200;

    vec_t vecs [19];
    vec_t sb [$];
    int   n_pass = 0;
    int   n_total = 0;
    int   m_bcnt = 0;
    int   m_mcnt = 0;

    function automatic vec_t mk(
        input logic [31:0] pc, input logic uv, input logic uj,
        input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
        input logic upt, input logic [31:0] uptgt,
        input logic e_pt, input logic [31:0] e_ptgt,
        input logic e_mp, input logic [31:0] e_rd);
        vec_t v;
        v.pc = pc; v.uv = uv; v.uj = uj; v.upc = upc;
        v.ut = ut; v.utgt = utgt; v.upt = upt; v.uptgt = uptgt;
        v.e_pt = e_pt; v.e_ptgt = e_ptgt; v.e_mp = e_mp; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                      name, act, exp, $time);
    endtask

    task automatic drive(input vec_t v);
        pc_f              = v.pc;
        upd_valid_e       = v.uv;
        upd_is_jump_e     = v.uj;
        upd_pc_e          = v.upc;
        upd_taken_e       = v.ut;
        upd_target_e      = v.utgt;
        upd_pred_taken_e  = v.upt;
        upd_pred_target_e = v.uptgt;
    endtask

    task automatic idle();
        upd_valid_e       = 1'b0;
        upd_is_jump_e     = 1'b0;
        upd_pc_e          = '0;
        upd_taken_e       = 1'b0;
        upd_target_e      = '0;
        upd_pred_taken_e  = 1'b0;
        upd_pred_target_e = '0;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        check("pred_taken", 32'(pred_taken_f), 32'(e.e_pt));
        check("pred_target", pred_target_f, e.e_ptgt);
        check("mispredict", 32'(mispredict_e), 32'(e.e_mp));
        check("redirect", redirect_pc_e, e.e_rd);
        check("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
        check("mispred_cnt", 32'(mispred_cnt), 32'(m_mcnt));
        if (e.uv && m_bcnt < 15) m_bcnt++;
        if (e.e_mp && m_mcnt < 15) m_mcnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        idle();
        pc_f = PA;
        #1;
        check("rst_pred_taken", 32'(pred_taken_f), 32'd0);
        check("rst_pred_target", pred_target_f, 32'd0);
        check("rst_branch_cnt", 32'(branch_cnt), 32'd0);
        check("rst_mispred_cnt", 32'(mispred_cnt), 32'd0);

        //              pc_f uv uj upc ut utgt upt uptgt | pt ptgt mp rd
        vecs[0]  = mk(PA, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0);
        vecs[1]  = mk(PA, 1, 0, PA, 1, T0, 0, 0,  0, 0,  1, T0);
        vecs[2]  = mk(PA, 0, 0, 0,  0, 0,  0, 0,  1, T0, 0, 0);
        vecs[3]  = mk(PA, 1, 0, PA, 0, 0,  1, T0, 1, T0, 1, 32'h0040_0014);
        vecs[4]  = mk(PA, 1, 0, PA, 0, 0,  0, 0,  0, 0,  0, 32'h0040_0014);
        vecs[5]  = mk(PA, 1, 0, PA, 0, 0,  0, 0,  0, 0,  0, 32'h0040_0014);
        vecs[6]  = mk(PA, 1, 0, PA, 1, T0, 0, 0,  0, 0,  1, T0);
        vecs[7]  = mk(PA, 1, 0, PA, 1, T0, 0, 0,  0, 0,  1, T0);
        vecs[8]  = mk(PA, 0, 0, 0,  0, 0,  0, 0,  1, T0, 0, 0);
        vecs[9]  = mk(PA, 1, 1, PB, 1, T1, 0, 0,  1, T0, 1, T1);
        vecs[10] = mk(PA, 0, 0, 0,  0, 0,  0, 0,  0, 0,  0, 0);
        vecs[11] = mk(PB, 0, 0, 0,  0, 0,  0, 0,  1, T1, 0, 0);
        vecs[12] = mk(PB, 1, 1, PB, 1, T2, 1, T1, 1, T1, 1, T2);
        vecs[13] = mk(PB, 0, 0, 0,  0, 0,  0, 0,  1, T2, 0, 0);
        vecs[14] = mk(PB, 0, 0, PB, 1, T1, 0, 0,  1, T2, 0, 0);
        vecs[15] = mk(PB, 1, 1, PB, 1, T2, 1, T2, 1, T2, 0, T2);
        vecs[16] = mk(32'h0040_0020, 1, 0, 32'h0040_0020, 0, 0, 0, 0,
                      0, 0, 0, 32'h0040_0024);
        vecs[17] = mk(32'h0040_0020, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[18] = mk(PB, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 0,
                      1, T2, 0, 32'h0000_0000);

        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 19; i++) run_vec(vecs[i]);

        // Drive both perf counters into saturation.
        for (int i = 0; i < 12; i++) begin
            run_vec(mk(PB, 1, 0, 32'h0040_0030, 0, 0, 1, 0,
                       1, T2, 1, 32'h0040_0034));
        end
        @(posedge clk);
        #1;
        idle();
        #1;
        check("sat_branch_cnt", 32'(branch_cnt), 32'd15);
        check("sat_mispred_cnt", 32'(mispred_cnt), 32'd15);

        // Asynchronous reset pulse between edges.
        pc_f = PB;
        #1;
        check("pre_rst_pred", 32'(pred_taken_f), 32'd1);
        reset = 1'b1;
        #1;
        check("async_pred_taken", 32'(pred_taken_f), 32'd0);
        check("async_pred_target", pred_target_f, 32'd0);
        check("async_branch_cnt", 32'(branch_cnt), 32'd0);
        check("async_mispred_cnt", 32'(mispred_cnt), 32'd0);
        reset = 1'b0;
        m_bcnt = 0;
        m_mcnt = 0;
        #1;
        check("post_rst_pred", 32'(pred_taken_f), 32'd0);

        // Update coinciding with reset across an edge is dropped.
        @(negedge clk);
        drive(mk(PA, 1, 1, PA, 1, T1, 0, 0, 0, 0, 0, 0));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle();
        pc_f = PA;
        #1;
        check("drop_pred_taken", 32'(pred_taken_f), 32'd0);
        check("drop_branch_cnt", 32'(branch_cnt), 32'd0);
        check("drop_mispred_cnt", 32'(mispred_cnt), 32'd0);

        // Table still trains normally after reset.
        run_vec(mk(PA, 1, 0, PA, 1, T0, 0, 0, 0, 0, 1, T0));
        run_vec(mk(PA, 0, 0, 0, 0, 0, 0, 0, 1, T0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
